// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM encoding
// and the default operand width.
package serial_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 8;

    // Code 2'd3 is never entered; the FSM treats it as a return to IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: the only arithmetic in the serial add/sub unit.
module full_adder (
    input  logic in_a,
    input  logic in_b,
    input  logic in_c,
    output logic c_out,
    output logic sum
);

    assign sum   = in_a ^ in_b ^ in_c;
    assign c_out = (in_a & in_b) | (in_c & (in_a ^ in_b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract unit. Operands are latched on start and
// fed LSB first through a single full_adder, one bit pair per clock. The
// carry is registered between bits. Subtraction is op_a + ~op_b + 1: op_b
// is inverted at load time, and the +1 is the initial carry.
module serial_addsub
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_launch;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Holds the sum bits produced so far. It is one bit narrower than the
    // result because the final sum bit goes straight into the result
    // register and never needs to be stored here.
    logic [WIDTH-2:0] r_acc_sr;
    logic [WIDTH-1:0] w_acc_next;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_overflow;

    logic             w_sum;
    logic             w_cell_cout;

    full_adder u_full_adder (
        .in_a  (r_a_sr[0]),
        .in_b  (r_b_sr[0]),
        .in_c  (r_carry),
        .c_out (w_cell_cout),
        .sum   (w_sum)
    );

    // Accumulator after this bit: the new sum bit enters at the MSB.
    assign w_acc_next = {w_sum, r_acc_sr};

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_launch     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_launch     = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // A start seen here relaunches with no idle bubble.
                if (start) begin
                    w_launch     = 1'b1;
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the values from before this edge.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand load, bit-serial shifting, and capture of the final results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_acc_sr   <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_launch) begin
            r_a_sr  <= op_a;
            r_b_sr  <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_cnt   <= CNT_LOAD;
        end else if (r_state == ST_SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_acc_sr <= w_acc_next[WIDTH-1:1];
            r_carry  <= w_cell_cout;
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_result   <= w_acc_next;
                r_c_out    <= w_cell_cout;
                // Signed overflow: carry into the MSB differs from carry out.
                r_overflow <= r_carry ^ w_cell_cout;
            end
        end
    end

    assign result   = r_result;
    assign c_out    = r_c_out;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed vectors,
// random operations against an integer reference model, start-during-SHIFT,
// back-to-back launch, and asynchronous reset mid-operation.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model from plain integer arithmetic: unsigned carry/no-borrow
    // and signed range overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] res, output logic co, output logic ov);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (s) begin
            res = W'((ua - ub + 256) % 256);
            co  = (ua >= ub);
            sr  = sa - sb;
        end else begin
            res = W'((ua + ub) % 256);
            co  = (ua + ub) >= 256;
            sr  = sa + sb;
        end
        ov = (sr > 127) || (sr < -128);
    endtask

    // Waits for done (bounded), counting busy cycles and busy&done overlaps.
    // Called just after the launch edge; returns at the negedge with done=1.
    task automatic collect(output int lat, output int busy_n, output int both);
        lat    = -1;
        busy_n = 0;
        both   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (busy && done) both++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output int busy_n, output int both);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        collect(lat, busy_n, both);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #1;
        checks++;
        if ({busy, done, result, c_out, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h c_out=%b ovf=%b, want all 0",
                     busy, done, result, c_out, overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [8] = '{8'h35, 8'h50, 8'h10, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'hC3};
        logic [W-1:0] tb [8] = '{8'h1A, 8'h20, 8'h20, 8'h01, 8'h01, 8'h01, 8'h00, 8'h3C};
        logic         ts [8] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        logic [W-1:0] er [8] = '{8'h4F, 8'h30, 8'hF0, 8'h80, 8'h00, 8'h7F, 8'h00, 8'hFF};
        logic         ec [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        logic         eo [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        int lat, busy_n, both;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], lat, busy_n, both);
            checks++;
            if (lat !== 9 || busy_n !== 8 || both !== 0) begin
                errors++;
                $display("FAIL dir%0d_timing: got latency=%0d busy_cycles=%0d overlap=%0d, want 9 8 0",
                         i, lat, busy_n, both);
            end
            checks++;
            if (result !== er[i] || c_out !== ec[i] || overflow !== eo[i]) begin
                errors++;
                $display("FAIL dir%0d_value: %h %s %h got result=%h c_out=%b ovf=%b, want %h %b %b",
                         i, ta[i], ts[i] ? "-" : "+", tb[i], result, c_out, overflow,
                         er[i], ec[i], eo[i]);
            end
            // done is a single-cycle pulse, and results hold while idle.
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== er[i]) begin
                errors++;
                $display("FAIL dir%0d_hold: got done=%b result=%h, want 0 %h",
                         i, done, result, er[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eres;
        logic         s, eco, eov;
        int lat, busy_n, both;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            model(a, b, s, eres, eco, eov);
            run_op(a, b, s, lat, busy_n, both);
            checks++;
            if (lat !== 9 || result !== eres || c_out !== eco || overflow !== eov) begin
                errors++;
                $display("FAIL rand%0d: %h %s %h got lat=%0d result=%h c_out=%b ovf=%b, want 9 %h %b %b",
                         i, a, s ? "-" : "+", b, lat, result, c_out, overflow, eres, eco, eov);
            end
        end
    endtask

    task automatic test_start_ignored();
        int done_n = 0;
        int done_at = -1;
        logic [W-1:0] res_at_done = '0;
        @(negedge clk);
        op_a  = 8'h12;
        op_b  = 8'h34;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                done_at     = k;
                res_at_done = result;
            end
            if (k == 3) begin
                op_a  = 8'hFF;
                op_b  = 8'hEE;
                sub   = 1'b1;
                start = 1'b1;
            end else if (k == 4) begin
                start = 1'b0;
            end
        end
        checks++;
        if (done_n !== 1 || done_at !== 9 || res_at_done !== 8'h46) begin
            errors++;
            $display("FAIL start_ignored: got dones=%0d at=%0d result=%h, want 1 9 46",
                     done_n, done_at, res_at_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy_n, both;
        @(negedge clk);
        op_a  = 8'h12;
        op_b  = 8'h34;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        // start stays high; the new operands are latched at the DONE edge.
        #1;
        op_a = 8'h01;
        op_b = 8'h01;
        collect(lat, busy_n, both);
        checks++;
        if (lat !== 9 || result !== 8'h46) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d result=%h, want 9 46", lat, result);
        end
        @(posedge clk);
        #1 start = 1'b0;
        collect(lat, busy_n, both);
        checks++;
        if (lat !== 9 || busy_n !== 8 || both !== 0 || result !== 8'h02 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d busy=%0d overlap=%0d result=%h c_out=%b, want 9 8 0 02 0",
                     lat, busy_n, both, result, c_out);
        end
    endtask

    task automatic test_async_reset();
        int lat, busy_n, both;
        // Leave nonzero registered outputs so the reset has something to clear.
        run_op(8'h7F, 8'h01, 1'b0, lat, busy_n, both);
        @(negedge clk);
        op_a  = 8'h5A;
        op_b  = 8'h66;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, c_out, overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h c_out=%b ovf=%b, want all 0",
                     busy, done, result, c_out, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        run_op(8'hAA, 8'h55, 1'b0, lat, busy_n, both);
        checks++;
        if (lat !== 9 || result !== 8'hFF || c_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_op: got lat=%0d result=%h c_out=%b ovf=%b, want 9 ff 0 0",
                     lat, result, c_out, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
